// File: rtl/char_ram_write_arbiter.sv
// Round-robin arbiter for the character RAM write port (port A) with locked bursts and a burst cap.
// Define CHAR_RAM_VBLANK_GATE_EN to hold off all writes and freeze arbitration while visible is high.
module char_ram_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 7,
    parameter int MAX_BURST = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        visible,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          lock,
    input  logic [NUM_REQ*ADDR_W-1:0]   reqAddr,
    input  logic [NUM_REQ*DATA_W-1:0]   reqData,
    output logic [NUM_REQ-1:0]          ack,
    output logic                        charRamWrEn,
    output logic [ADDR_W-1:0]           charRamAddr,
    output logic [DATA_W-1:0]           charRamData,
    output logic [$clog2(NUM_REQ)-1:0]  ownerId,
    output logic                        busy
);

    localparam int         IDX_W       = $clog2(NUM_REQ);
    localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [7:0]         burst_cnt_q, burst_cnt_d;

    logic               wr_en_q, wr_en_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [IDX_W-1:0]   owner_id_q, owner_id_d;

    logic               stall;
    logic               rr_found;
    logic [IDX_W-1:0]   rr_win;
    logic               grant_vld;
    logic [IDX_W-1:0]   grant_idx;

`ifdef CHAR_RAM_VBLANK_GATE_EN
    assign stall = visible;
`else
    logic unused_visible;
    assign stall          = 1'b0;
    assign unused_visible = visible;
`endif

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    // Round-robin search: first set req bit at or above rr_ptr_q, wrapping at NUM_REQ.
    always_comb begin
        int               idx;
        logic [IDX_W-1:0] cand;
        // NOTE: every combinationally written signal gets a default first so no latch is inferred.
        rr_found = 1'b0;
        rr_win   = '0;
        idx      = 0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = IDX_W'(idx);
            if (!rr_found && req[cand]) begin
                rr_found = 1'b1;
                rr_win   = cand;
            end
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_win;
        if (!stall) begin
            if (state_q == BURST) begin
                grant_vld = req[owner_q];
                grant_idx = owner_q;
            end else begin
                grant_vld = rr_found;
            end
        end
    end

    // State register, including the registered output stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
            wr_en_q     <= 1'b0;
            ack_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            owner_id_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            wr_en_q     <= wr_en_d;
            ack_q       <= ack_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            owner_id_q  <= owner_id_d;
        end
    end

    // Next-state logic: a bubble with lock still held keeps the burst; lock low or the cap ends it.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        if (!stall) begin
            case (state_q)
                IDLE: begin
                    if (rr_found) begin
                        rr_ptr_d = next_idx(rr_win);
                        if (lock[rr_win] && (MAX_BURST > 1)) begin
                            state_d     = BURST;
                            owner_d     = rr_win;
                            burst_cnt_d = 8'd1;
                        end
                    end
                end
                BURST: begin
                    if (req[owner_q]) begin
                        burst_cnt_d = burst_cnt_q + 8'd1;
                    end
                    if (!lock[owner_q] ||
                        (req[owner_q] && ((burst_cnt_q + 8'd1) == MAX_BURST_C))) begin
                        state_d     = IDLE;
                        rr_ptr_d    = next_idx(owner_q);
                        burst_cnt_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic: address, data and ownerId hold their last values when nothing is granted.
    always_comb begin
        wr_en_d    = grant_vld;
        ack_d      = '0;
        addr_d     = addr_q;
        data_d     = data_q;
        owner_id_d = owner_id_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_vld && (grant_idx == IDX_W'(i))) begin
                ack_d[i]   = 1'b1;
                addr_d     = reqAddr[ADDR_W*i +: ADDR_W];
                data_d     = reqData[DATA_W*i +: DATA_W];
                owner_id_d = grant_idx;
            end
        end
    end

    assign ack         = ack_q;
    assign charRamWrEn = wr_en_q;
    assign charRamAddr = addr_q;
    assign charRamData = data_q;
    assign ownerId     = owner_id_q;
    assign busy        = (state_q == BURST);

endmodule

// File: doc/char_ram_write_arbiter.md
# char_ram_write_arbiter

Shares the single write port (port A) of the character RAM between up to eight text producers: the timer display, score/status writers and message banners. Each cycle it picks one requesting producer round-robin and registers its address and data onto the RAM write port. It supports locked bursts for whole-string writes, with a starvation cap. It sits between the producers and `characterRAM`; the read side (port B, text generator) is untouched.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8).
- `ADDR_W`, 13, character RAM address width.
- `DATA_W`, 7, character code width.
- `MAX_BURST`, 16, maximum consecutive writes granted to one locked owner (1..255).

Ports:
- `clk`  in  1  pixel/system clock; all state on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `visible`  in  1  active-video flag from the timing generator; used only with the gate macro.
- `req`  in  NUM_REQ  bit i: requester i presents a valid word.
- `lock`  in  NUM_REQ  bit i: requester i asks to keep ownership after this word.
- `reqAddr`  in  NUM_REQ*ADDR_W  packed; requester i occupies [ADDR_W*i +: ADDR_W].
- `reqData`  in  NUM_REQ*DATA_W  packed; requester i occupies [DATA_W*i +: DATA_W].
- `ack`  out  NUM_REQ  one-hot registered pulse: the word requester i presented last cycle was written.
- `charRamWrEn`  out  1  write strobe to character RAM port A.
- `charRamAddr`  out  ADDR_W  write address.
- `charRamData`  out  DATA_W  write data.
- `ownerId`  out  $clog2(NUM_REQ)  current or last winner index.
- `busy`  out  1  high while in the BURST state.

## Operation
- State machine with two states:
  - IDLE: round-robin arbitration.
  - BURST: fixed owner.
- Registers:
  - `rrPtr`: next-priority index.
  - `owner`.
  - `burstCnt`: 8 bits.
- IDLE, at each edge:
  - Winner w is the first set bit of `req`, scanning from `rrPtr` upward with wrap at NUM_REQ.
  - No winner: `charRamWrEn`=0 and `ack`=0. Address and data hold their last values.
  - Winner: register `charRamWrEn`=1, `charRamAddr`/`charRamData` from slot w, `ack[w]`=1, `ownerId`=w, `rrPtr`=(w+1) mod NUM_REQ.
  - If `lock[w]` is also set and MAX_BURST>1: go to BURST with `owner`=w and `burstCnt`=1.
- BURST, at each edge:
  - `req[owner]`=1: write owner's word, `ack[owner]`=1, `burstCnt`+1.
  - `req[owner]`=0: no write, `ack`=0. Other requesters stay blocked; this is a bubble.
  - Exit to IDLE when either:
    - `lock[owner]` was 0 at this edge; the word presented with it, if any, is still written; or
    - `burstCnt` reaches MAX_BURST with this write.
  - On exit, `rrPtr`=(owner+1) mod NUM_REQ, so a capped owner cannot immediately re-win.
- Requester contract:
  - Hold `req`, address and data stable until `ack` is seen.
  - In the `ack` cycle, present the next word or drop `req`. Combinational use of `ack` is allowed.
  - Leaving `req` high with an unchanged word produces a duplicate write.
- `rrPtr`, `owner` and `ownerId` always stay within 0..NUM_REQ-1.

## Timing
- Latency from the edge that samples `req` to `charRamWrEn`: 1 cycle.
- `ack` is coincident with `charRamWrEn`.
- Throughput is one word per cycle. A single requester holding `req` streams back-to-back.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset asserts asynchronously. While in reset:
  - `charRamWrEn`=0, `ack`=0, `charRamAddr`=0, `charRamData`=0, `ownerId`=0, `busy`=0.
  - State is IDLE, `rrPtr`=0, `burstCnt`=0.
- Reset mid-burst aborts the burst; no pending write is issued.
- First arbitration happens at the first edge after reset deasserts.

## Configuration
- `CHAR_RAM_VBLANK_GATE_EN` defined:
  - While `visible`=1, no write is issued and `ack`=0.
  - State, `owner`, `rrPtr` and `burstCnt` are frozen.
  - Arbitration resumes at the first edge with `visible`=0. This avoids mid-frame glyph tearing.
- Macro undefined:
  - `visible` is ignored and writes proceed in any region.

## Test plan
- Reset release, `req`=4'b0010 held for 3 cycles with addr 0x010/0x011/0x012 -> `charRamWrEn` high for 3 consecutive cycles starting 1 cycle after first sample, with the matching addresses, `ack[1]` concurrent, `ownerId`=1.
- `req`=4'b1111 held, no lock, from reset -> grants in order 0,1,2,3,0, one per cycle, each `ack` one-hot.
- Requester 0 locked with 20 words and requester 2 requesting -> 16 writes for 0 with `busy`=1, then 1 write for 2, then 0 resumes with 4 words.
- Requester 0 locked, drops `req` for 2 cycles while requester 1 requests -> `charRamWrEn`=0 for 2 cycles and `ack[1]` stays 0 until 0 drops `lock`.
- Macro defined, `visible`=1 and `req`=4'b0001 -> no write; `visible` falls -> write 1 cycle later. Macro undefined -> write 1 cycle after `req` regardless of `visible`.
- `reset` asserted mid-burst at `burstCnt`=5 -> all outputs 0 immediately without a clock edge; after release with `req`=4'b1001, requester 0 wins first.
